// File: rtl/audio_handshake_arbiter.sv
// Round-robin arbiter sharing one 4-phase Req/Ack sample channel between N_SRC producers.
// Optional watchdog enabled by defining AUDIO_ARB_TIMEOUT_EN.
module audio_handshake_arbiter #(
  parameter int N_SRC       = 2,
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_SRC-1:0]          src_valid,
  input  logic [N_SRC*DATA_W-1:0]   src_data,
  output logic [N_SRC-1:0]          src_ready,
  output logic [$clog2(N_SRC)-1:0]  grant_id,
  output logic [DATA_W-1:0]         dout,
  output logic                      Req,
  input  logic                      Ack,
  output logic                      busy,
  output logic                      timeout
);

  localparam int ID_W = $clog2(N_SRC);

  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic [SYNC_STAGES-1:0] fill;
  logic                   ack_s;
  logic                   sync_ok;
  logic [ID_W-1:0]        rr;
  logic [ID_W-1:0]        win;
  logic                   any_valid;
  logic                   wd_hit;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % N_SRC;
    return ID_W'(s);
  endfunction

  // Ack synchroniser; fill blocks grants until the chain holds real samples of Ack after reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_sync <= '0;
      fill     <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], Ack};
      fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign ack_s   = ack_sync[SYNC_STAGES-1];
  assign sync_ok = fill[SYNC_STAGES-1];

  // First valid source after the rr pointer; descending scan so the nearest one wins
  always_comb begin
    win       = '0;
    any_valid = 1'b0;
    for (int k = N_SRC; k >= 1; k--) begin
      if (src_valid[wrap_idx(rr, k)]) begin
        win       = wrap_idx(rr, k);
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    src_ready = '0;
    case (state)
      IDLE: begin
        if (rst && sync_ok && !ack_s && any_valid) begin
          src_ready[win] = 1'b1;
          state_nxt      = REQ;
        end
      end
      REQ:     if (ack_s || wd_hit) state_nxt = REL;
      REL:     if (!ack_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      Req      <= 1'b0;
      dout     <= '0;
      grant_id <= '0;
      rr       <= ID_W'(N_SRC - 1);
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == REQ) begin
        Req      <= 1'b1;
        dout     <= src_data[int'(win)*DATA_W +: DATA_W];
        grant_id <= win;
        rr       <= win;
      end else if (state == REQ && state_nxt == REL) begin
        Req <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef AUDIO_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             timeout_q;

  // Counter restarts on every state change and parks at the limit while stuck in REL
  assign wd_hit = (state != IDLE) && (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == IDLE || state_nxt != state) wd_cnt <= '0;
      else if (!wd_hit)                        wd_cnt <= wd_cnt + 1'b1;
      if (wd_hit) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_audio_handshake_arbiter.sv
// Directed bench for audio_handshake_arbiter: table of loopback transactions plus
// hand-timed sequences for stale Ack, mid-transaction reset, Ack glitch and watchdog.
module tb_audio_handshake_arbiter;

  localparam int N_SRC       = 2;
  localparam int DATA_W      = 12;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT_CYC = 16;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [N_SRC-1:0]        src_valid = '0;
  logic [N_SRC*DATA_W-1:0] src_data = '0;
  logic [N_SRC-1:0]        src_ready;
  logic [0:0]              grant_id;
  logic [DATA_W-1:0]       dout;
  logic                    Req;
  logic                    Ack;
  logic                    busy;
  logic                    timeout;

  logic       loop_en = 1'b1;
  logic       ack_man = 1'b0;
  logic [1:0] ack_d = '0;
  logic [1:0] tb_sync = '0;

  int n_checks = 0;
  int n_pass   = 0;

  audio_handshake_arbiter #(
    .N_SRC(N_SRC), .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .grant_id(grant_id), .dout(dout),
    .Req(Req), .Ack(Ack), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Receiver model: Ack follows Req two clocks later when looping back
  always @(posedge clk) ack_d <= {ack_d[0], Req};
  assign Ack = loop_en ? ack_d[1] : ack_man;

  // Reference view of the synchronised Ack
  always @(posedge clk) tb_sync <= {tb_sync[0], Ack};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // While Req is high dout must not move; Req may only fall after ack_s=1 or a watchdog trip
  logic              prev_req = 1'b0;
  logic              prev_rst = 1'b0;
  logic              prev_acks = 1'b0;
  logic [DATA_W-1:0] prev_dout = '0;
  always @(negedge clk) begin
    if (rst && prev_rst && prev_req) begin
      if (Req) check("dout_stable", dout, prev_dout);
      else     check("req_fall_cause", prev_acks | timeout, 1);
    end
    prev_req  = Req;
    prev_rst  = rst;
    prev_acks = tb_sync[1];
    prev_dout = dout;
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (src_ready != '0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) check("wait_ready_bound", 0, 1);
  endtask

  task automatic wait_req_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (!Req) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) check("wait_req_low_bound", 0, 1);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (!busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) check("wait_idle_bound", 0, 1);
  endtask

  task automatic finish_txn();
    bit ok;
    loop_en = 1'b1;
    wait_idle(ok);
  endtask

  typedef struct {
    logic [1:0]        valid;
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
    logic [0:0]        g;
    logic [DATA_W-1:0] dv;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not reach the end");
    $fatal(1, "time limit");
  end

  initial begin
    bit ok;
    int held;

    tbl[0] = '{2'b01, 12'hABC, 12'h000, 1'b0, 12'hABC};
    tbl[1] = '{2'b11, 12'h111, 12'h222, 1'b1, 12'h222};
    tbl[2] = '{2'b11, 12'h111, 12'h222, 1'b0, 12'h111};
    tbl[3] = '{2'b11, 12'h111, 12'h222, 1'b1, 12'h222};
    tbl[4] = '{2'b10, 12'h000, 12'h3C5, 1'b1, 12'h3C5};
    tbl[5] = '{2'b01, 12'h5A5, 12'h000, 1'b0, 12'h5A5};
    tbl[6] = '{2'b11, 12'hFFF, 12'h000, 1'b1, 12'h000};
    tbl[7] = '{2'b11, 12'hFFF, 12'h000, 1'b0, 12'hFFF};

    // Reset state, with requests pending to show src_ready is held off
    rst = 1'b0;
    src_valid = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req", Req, 0);
    check("rst_dout", dout, 0);
    check("rst_src_ready", src_ready, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    @(negedge clk);
    rst = 1'b1;

    // Loopback transactions: single source, then rotation with both valid
    for (int i = 0; i < 8; i++) begin
      src_valid = tbl[i].valid;
      src_data  = {tbl[i].d1, tbl[i].d0};
      wait_ready(ok);
      if (ok) begin
        check("accept_onehot", src_ready, 2'b01 << tbl[i].g);
        @(negedge clk); #1;
        check("req_after_accept", Req, 1);
        check("dout_granted", dout, tbl[i].dv);
        check("grant_id", grant_id, tbl[i].g);
        check("busy_in_req", busy, 1);
        check("ready_low_in_req", src_ready, 0);
        wait_req_low(ok);
        if (ok) check("dout_hold_after_req", dout, tbl[i].dv);
        wait_idle(ok);
      end
    end

    // Stale Ack held high across reset release
    src_valid = 2'b00;
    loop_en = 1'b0;
    ack_man = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    src_valid = 2'b01;
    src_data = {12'h000, 12'h123};
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      check("stale_ack_no_ready", src_ready, 0);
      check("stale_ack_no_req", Req, 0);
    end
    ack_man = 1'b0;
    @(negedge clk); #1;
    check("ack_fall_sync1_no_ready", src_ready, 0);
    @(negedge clk); #1;
    check("ack_fall_sync2_ready", src_ready, 2'b01);
    @(negedge clk); #1;
    check("stale_req", Req, 1);
    check("stale_dout", dout, 12'h123);
    src_valid = 2'b00;
    finish_txn();

    // Reset while in REQ
    loop_en = 1'b0;
    ack_man = 1'b0;
    src_valid = 2'b10;
    src_data = {12'h456, 12'h000};
    wait_ready(ok);
    check("pre_reset_accept", src_ready, 2'b10);
    @(negedge clk); #1;
    check("pre_reset_req", Req, 1);
    check("pre_reset_grant", grant_id, 1);
    rst = 1'b0;
    @(negedge clk); #1;
    check("midrst_req", Req, 0);
    check("midrst_busy", busy, 0);
    check("midrst_dout", dout, 0);
    check("midrst_grant", grant_id, 0);
    check("midrst_ready", src_ready, 0);
    rst = 1'b1;
    src_valid = 2'b11;
    src_data = {12'h456, 12'h789};
    wait_ready(ok);
    check("post_rst_src0_first", src_ready, 2'b01);
    @(negedge clk); #1;
    check("post_rst_dout", dout, 12'h789);
    check("post_rst_grant", grant_id, 0);
    src_valid = 2'b00;
    finish_txn();

    // One-cycle Ack glitch
    loop_en = 1'b0;
    ack_man = 1'b0;
    src_valid = 2'b01;
    src_data = {12'h000, 12'h777};
    wait_ready(ok);
    check("glitch_accept", src_ready, 2'b01);
    @(negedge clk); #1;
    check("glitch_req_up", Req, 1);
    src_valid = 2'b00;
    ack_man = 1'b1;
    @(negedge clk);
    ack_man = 1'b0;
    #1;
    check("glitch_req_hold1", Req, 1);
    @(negedge clk); #1;
    check("glitch_req_hold2", Req, 1);
    check("glitch_dout", dout, 12'h777);
    @(negedge clk); #1;
    check("glitch_req_drop", Req, 0);
    check("glitch_busy_rel", busy, 1);
    @(negedge clk); #1;
    check("glitch_idle", busy, 0);

    // Ack never rises
    src_valid = 2'b11;
    src_data = {12'h0BB, 12'h0AA};
    wait_ready(ok);
    check("noack_accept", src_ready, 2'b10);
    held = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk); #1;
      if (Req) held++;
    end
    check("noack_req_held_cycles", held, 16);
`ifdef AUDIO_ARB_TIMEOUT_EN
    @(negedge clk); #1;
    check("wd_req_drop", Req, 0);
    check("wd_timeout_set", timeout, 1);
    @(negedge clk); #1;
    check("wd_back_idle", busy, 0);
    check("wd_next_ready", src_ready, 2'b01);
    @(negedge clk); #1;
    check("wd_next_req", Req, 1);
    check("wd_next_grant", grant_id, 0);
    check("wd_next_dout", dout, 12'h0AA);
    check("wd_timeout_sticky", timeout, 1);
    src_valid = 2'b00;
    finish_txn();
    check("wd_timeout_sticky_end", timeout, 1);
`else
    repeat (24) @(negedge clk);
    #1;
    check("noack_req_still_high", Req, 1);
    check("noack_grant", grant_id, 1);
    check("noack_timeout_tied", timeout, 0);
    src_valid = 2'b00;
    finish_txn();
    check("noack_timeout_end", timeout, 0);
`endif

    // Final reset clears everything, including a sticky timeout
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check("final_rst_timeout", timeout, 0);
    check("final_rst_req", Req, 0);
    rst = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
